// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//   Round-robin arbiter that lets NUM_REQ requesters share one apb_master
//   bridge-side command interface. The winning command is latched onto the
//   bridge outputs and held until the APB ACCESS phase completes
//   (psel & penable & pready). The winner then gets a one-cycle done pulse,
//   and its grant is held until psel drops.
//
// Ports
//   pclk_i            clock, rising edge
//   prst_i            synchronous active-low reset
//   req_valid_i       per-requester command valid (held until done)
//   req_write_i       per-requester write flag (1 = write)
//   req_addr_i        packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata_i       packed write data, same packing
//   grant_o           one-hot owner of the bridge
//   done_o            one-cycle completion pulse to the owner
//   rdata_o           data of the most recent completed read
//   apb_transfer_o    transfer request to apb_master
//   apb_wr_rd_o       direction to apb_master (1 = write)
//   apb_write_addr_o  write address to apb_master (0 for reads)
//   apb_read_addr_o   read address to apb_master (0 for writes)
//   apb_write_data_o  write data to apb_master (0 for reads)
//   apb_read_data_i   read data returned by apb_master
//   psel_i            monitored APB psel
//   penable_i         monitored APB penable
//   pready_i          monitored APB pready
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          pclk_i,
    input  logic                          prst_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ-1:0]            req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            grant_o,
    output logic [NUM_REQ-1:0]            done_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          apb_transfer_o,
    output logic                          apb_wr_rd_o,
    output logic [ADDR_WIDTH-1:0]         apb_write_addr_o,
    output logic [ADDR_WIDTH-1:0]         apb_read_addr_o,
    output logic [DATA_WIDTH-1:0]         apb_write_data_o,
    input  logic [DATA_WIDTH-1:0]         apb_read_data_i,
    input  logic                          psel_i,
    input  logic                          penable_i,
    input  logic                          pready_i
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_owner;
    logic [NUM_REQ-1:0]      r_grant;
    logic [NUM_REQ-1:0]      r_done;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_transfer;
    logic                    r_wr_rd;
    logic [ADDR_WIDTH-1:0]   r_write_addr;
    logic [ADDR_WIDTH-1:0]   r_read_addr;
    logic [DATA_WIDTH-1:0]   r_write_data;

    logic                    w_any_req;
    logic                    w_found_hi;
    logic [IDX_W-1:0]        w_idx_hi;
    logic [IDX_W-1:0]        w_idx_lo;
    logic [IDX_W-1:0]        w_winner;
    logic [NUM_REQ-1:0]      w_grant_vec;
    logic                    w_win_write;
    logic [ADDR_WIDTH-1:0]   w_win_addr;
    logic [DATA_WIDTH-1:0]   w_win_wdata;
    logic                    w_access_done;
    logic [IDX_W-1:0]        w_rr_next;

    // Round-robin pick: lowest valid index at or above rr_ptr, otherwise
    // wrap to the lowest valid index overall. The descending scan leaves the
    // lowest qualifying index in each candidate.
    always_comb begin
        w_any_req  = |req_valid_i;
        w_found_hi = 1'b0;
        w_idx_hi   = '0;
        w_idx_lo   = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid_i[IDX_W'(i)]) begin
                w_idx_lo = IDX_W'(i);
                if (IDX_W'(i) >= r_rr_ptr) begin
                    w_idx_hi   = IDX_W'(i);
                    w_found_hi = 1'b1;
                end
            end
        end
        w_winner = w_found_hi ? w_idx_hi : w_idx_lo;
    end

    // Command fields of the current winner, sliced out of the packed buses.
    always_comb begin
        w_grant_vec = NUM_REQ'(1) << w_winner;
        w_win_write = req_write_i[w_winner];
        w_win_addr  = req_addr_i[32'(w_winner) * ADDR_WIDTH +: ADDR_WIDTH];
        w_win_wdata = req_wdata_i[32'(w_winner) * DATA_WIDTH +: DATA_WIDTH];
    end

    // APB ACCESS handshake and the pointer value that puts the owner last.
    always_comb begin
        w_access_done = psel_i & penable_i & pready_i;
        w_rr_next     = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);
    end

    // Arbitration FSM with registered bridge outputs.
    always_ff @(posedge pclk_i) begin
        if (!prst_i) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_grant      <= '0;
            r_done       <= '0;
            r_rdata      <= '0;
            r_transfer   <= 1'b0;
            r_wr_rd      <= 1'b0;
            r_write_addr <= '0;
            r_read_addr  <= '0;
            r_write_data <= '0;
        end else begin
            // done is a single-cycle pulse
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state      <= ST_BUSY;
                        r_owner      <= w_winner;
                        r_grant      <= w_grant_vec;
                        r_transfer   <= 1'b1;
                        r_wr_rd      <= w_win_write;
                        // only the address/data lane for the active direction is driven
                        r_write_addr <= w_win_write ? w_win_addr  : '0;
                        r_read_addr  <= w_win_write ? '0 : w_win_addr;
                        r_write_data <= w_win_write ? w_win_wdata : '0;
                    end
                end
                ST_BUSY: begin
                    if (w_access_done) begin
                        r_state      <= ST_RELEASE;
                        r_done       <= r_grant;
                        if (!r_wr_rd) begin
                            r_rdata <= apb_read_data_i;
                        end
                        r_transfer   <= 1'b0;
                        r_wr_rd      <= 1'b0;
                        r_write_addr <= '0;
                        r_read_addr  <= '0;
                        r_write_data <= '0;
                        r_rr_ptr     <= w_rr_next;
                    end
                end
                ST_RELEASE: begin
                    // hold ownership until the bridge has left the transfer
                    if (!psel_i) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    assign grant_o          = r_grant;
    assign done_o           = r_done;
    assign rdata_o          = r_rdata;
    assign apb_transfer_o   = r_transfer;
    assign apb_wr_rd_o      = r_wr_rd;
    assign apb_write_addr_o = r_write_addr;
    assign apb_read_addr_o  = r_read_addr;
    assign apb_write_data_o = r_write_data;

    // Structural invariants of the grant/done outputs.
    a_grant_onehot : assert property (@(posedge pclk_i) disable iff (!prst_i)
        $onehot0(grant_o));
    a_done_onehot : assert property (@(posedge pclk_i) disable iff (!prst_i)
        $onehot0(done_o));
    a_done_owner : assert property (@(posedge pclk_i) disable iff (!prst_i)
        ((done_o & ~grant_o) == '0));
    a_transfer_owned : assert property (@(posedge pclk_i) disable iff (!prst_i)
        (apb_transfer_o |-> (grant_o != '0)));

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
//   apb_req_arbiter driving a behavioural apb_master + 16-word memory slave
//   with programmable wait states and an optional psel linger after ACCESS.
//   A transaction-level reference model (round-robin pick, memory image,
//   last read data) predicts grant/done/bridge outputs every cycle.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic              prst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [AW-1:0]     cmd_addr  [NR];
    logic [DW-1:0]     cmd_wdata [NR];
    logic [NR*AW-1:0]  req_addr_bus;
    logic [NR*DW-1:0]  req_wdata_bus;

    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic [DW-1:0]     rdata;
    logic              apb_transfer;
    logic              apb_wr_rd;
    logic [AW-1:0]     apb_write_addr;
    logic [AW-1:0]     apb_read_addr;
    logic [DW-1:0]     apb_write_data;
    logic [DW-1:0]     prdata;
    logic              psel;
    logic              penable;
    logic              pready;

    always_comb begin
        for (int i = 0; i < int'(NR); i++) begin
            req_addr_bus[i*AW +: AW]  = cmd_addr[i];
            req_wdata_bus[i*DW +: DW] = cmd_wdata[i];
        end
    end

    apb_req_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .pclk_i           (pclk),
        .prst_i           (prst),
        .req_valid_i      (req_valid),
        .req_write_i      (req_write),
        .req_addr_i       (req_addr_bus),
        .req_wdata_i      (req_wdata_bus),
        .grant_o          (grant),
        .done_o           (done),
        .rdata_o          (rdata),
        .apb_transfer_o   (apb_transfer),
        .apb_wr_rd_o      (apb_wr_rd),
        .apb_write_addr_o (apb_write_addr),
        .apb_read_addr_o  (apb_read_addr),
        .apb_write_data_o (apb_write_data),
        .apb_read_data_i  (prdata),
        .psel_i           (psel),
        .penable_i        (penable),
        .pready_i         (pready)
    );

    // ---------------- behavioural apb_master + memory slave ----------------
    typedef enum logic [1:0] {M_IDLE, M_SETUP, M_ACCESS, M_LINGER} mst_t;
    mst_t        m_st = M_IDLE;
    logic        m_write = 1'b0;
    logic [3:0]  m_idx = '0;
    logic [31:0] m_wdata = '0;
    int          m_wcnt = 0;
    int          m_lcnt = 0;
    logic        m_done = 1'b0;
    logic [31:0] slv_mem [16];
    int          cfg_wait = 0;
    int          cfg_linger = 0;

    assign psel    = (m_st != M_IDLE);
    assign penable = (m_st == M_ACCESS);
    assign pready  = (m_st == M_ACCESS) && (m_wcnt == 0);
    assign prdata  = slv_mem[m_idx];

    always @(posedge pclk) begin
        m_done <= 1'b0;
        if (!prst) begin
            m_st   <= M_IDLE;
            m_wcnt <= 0;
            m_lcnt <= 0;
        end else begin
            case (m_st)
                M_IDLE: if (apb_transfer) begin
                    m_st    <= M_SETUP;
                    m_write <= apb_wr_rd;
                    m_idx   <= apb_wr_rd ? apb_write_addr[3:0] : apb_read_addr[3:0];
                    m_wdata <= apb_write_data;
                end
                M_SETUP: begin
                    m_st   <= M_ACCESS;
                    m_wcnt <= cfg_wait;
                end
                M_ACCESS: if (m_wcnt == 0) begin
                    if (m_write) slv_mem[m_idx] <= m_wdata;
                    m_done <= 1'b1;
                    m_lcnt <= cfg_linger;
                    m_st   <= (cfg_linger != 0) ? M_LINGER : M_IDLE;
                end else begin
                    m_wcnt <= m_wcnt - 1;
                end
                M_LINGER: if (m_lcnt <= 1) m_st <= M_IDLE; else m_lcnt <= m_lcnt - 1;
                default: m_st <= M_IDLE;
            endcase
        end
    end

    // ---------------- reference model and checking ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          rr = 0;
    int          owner = -1;
    bit          in_rel = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] ref_mem [16];
    logic        g_write;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [NR-1:0] prev_valid;
    logic        prev_psel;
    logic        prev_rst;
    int          done_owner = -1;
    int          n_done_seen = 0;
    int          busy_cyc = 0;
    int          grants_q [$];
    logic [NR-1:0] hold_mask = '0;
    bit          rand_mode = 1'b0;
    bit          drain = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int start);
        for (int k = 0; k < int'(NR); k++) begin
            int idx;
            idx = (start + k) % int'(NR);
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int o);
        if (o < 0) return '0;
        return NR'(1) << o;
    endfunction

    task automatic rand_cmd(input int i);
        req_write[i] = 1'($urandom_range(0, 1));
        cmd_addr[i]  = 32'($urandom_range(0, 15));
        cmd_wdata[i] = $urandom;
    endtask

    // One clock: snapshot what the coming edge samples, check at negedge,
    // then let the requesters react.
    task automatic step();
        prev_valid = req_valid;
        prev_psel  = psel;
        prev_rst   = prst;
        @(negedge pclk);
        done_owner = -1;
        if (!prev_rst) begin
            check_val("rst_grant", grant, 0);
            check_val("rst_done", done, 0);
            check_val("rst_rdata", rdata, 0);
            check_val("rst_transfer", apb_transfer, 0);
            check_val("rst_wr_rd", apb_wr_rd, 0);
            check_val("rst_waddr", apb_write_addr, 0);
            check_val("rst_raddr", apb_read_addr, 0);
            check_val("rst_wdata", apb_write_data, 0);
            rr = 0; owner = -1; in_rel = 1'b0; exp_rdata = '0; busy_cyc = 0;
        end else begin
            if (owner < 0) begin
                if (prev_valid != '0) begin
                    owner   = rr_pick(prev_valid, rr);
                    g_write = req_write[owner];
                    g_addr  = cmd_addr[owner];
                    g_wdata = cmd_wdata[owner];
                    grants_q.push_back(owner);
                end
            end else if (in_rel) begin
                if (!prev_psel) begin
                    owner  = -1;
                    in_rel = 1'b0;
                end
            end else if (m_done) begin
                done_owner = owner;
                in_rel     = 1'b1;
                rr         = (owner + 1) % int'(NR);
                if (g_write) ref_mem[g_addr[3:0]] = g_wdata;
                else         exp_rdata = ref_mem[g_addr[3:0]];
                n_done_seen++;
            end
            check_val("grant", grant, onehot(owner));
            check_val("done", done, onehot(done_owner));
            if (owner >= 0 && !in_rel) begin
                check_val("busy_transfer", apb_transfer, 1);
                check_val("busy_wr_rd", apb_wr_rd, g_write);
                check_val("busy_waddr", apb_write_addr, g_write ? g_addr : 32'd0);
                check_val("busy_raddr", apb_read_addr, g_write ? 32'd0 : g_addr);
                check_val("busy_wdata", apb_write_data, g_write ? g_wdata : 32'd0);
            end else begin
                check_val("idle_transfer", apb_transfer, 0);
                check_val("idle_wr_rd", apb_wr_rd, 0);
            end
            check_val("rdata", rdata, exp_rdata);
            busy_cyc = (owner >= 0) ? busy_cyc + 1 : 0;
            if (busy_cyc == 100) check_val("owner_timeout", busy_cyc, 0);
        end
        for (int i = 0; i < int'(NR); i++) begin
            if (done_owner == i) begin
                if (rand_mode && !drain && $urandom_range(0, 1) == 1) rand_cmd(i);
                else if (!hold_mask[i]) req_valid[i] = 1'b0;
            end else if (rand_mode) begin
                if (!req_valid[i]) begin
                    if (!drain && $urandom_range(0, 3) == 0) begin
                        rand_cmd(i);
                        req_valid[i] = 1'b1;
                    end
                end else if (i == owner && !in_rel && $urandom_range(0, 2) == 0) begin
                    rand_cmd(i);   // must be ignored by the arbiter
                end
            end
        end
        if (rand_mode) begin
            prst = drain ? 1'b1 : ($urandom_range(0, 299) != 0);
            if (m_st == M_IDLE) begin
                cfg_wait   = $urandom_range(0, 3);
                cfg_linger = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            end
        end
    endtask

    task automatic wait_done(input int max_cyc, input string tag);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            step();
            if (done_owner >= 0) seen = 1'b1;
        end
        check_val(tag, seen, 1);
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < max_cyc && !idle; c++) begin
            step();
            if (owner < 0 && req_valid == '0) idle = 1'b1;
        end
        check_val(tag, idle, 1);
    endtask

    initial begin
        int base;
        bit hit;
        for (int k = 0; k < 16; k++) begin
            slv_mem[k] = '0;
            ref_mem[k] = '0;
        end
        prst = 1'b0;
        req_valid = '0;
        req_write = '0;
        for (int i = 0; i < int'(NR); i++) begin
            cmd_addr[i]  = '0;
            cmd_wdata[i] = '0;
        end

        // 1. reset for two edges, then idle with no requests
        step();
        step();
        prst = 1'b1;
        for (int c = 0; c < 3; c++) step();
        check_val("t1_transfer", apb_transfer, 0);

        // 2. single write from req0
        req_write[0] = 1'b1; cmd_addr[0] = 32'd10; cmd_wdata[0] = 32'd20;
        req_valid[0] = 1'b1;
        step();
        check_val("t2_transfer", apb_transfer, 1);
        check_val("t2_wr_rd", apb_wr_rd, 1);
        check_val("t2_waddr", apb_write_addr, 10);
        check_val("t2_wdata", apb_write_data, 20);
        wait_done(50, "t2_done_seen");
        check_val("t2_done", done, 3'b001);
        wait_idle(50, "t2_idle");
        check_val("t2_mem", slv_mem[10], 20);

        // 3. contention between req0 and req1, both holding valid
        grants_q.delete();
        hold_mask = 3'b011;
        req_write[0] = 1'b1; cmd_addr[0] = 32'd1; cmd_wdata[0] = 32'h11;
        req_write[1] = 1'b1; cmd_addr[1] = 32'd2; cmd_wdata[1] = 32'h22;
        req_valid[0] = 1'b1;
        step();
        req_valid[1] = 1'b1;
        base = n_done_seen;
        for (int c = 0; c < 200 && (n_done_seen - base) < 4; c++) step();
        hold_mask = '0;
        req_valid = '0;
        check_val("t3_ngrants", grants_q.size(), 4);
        for (int k = 0; k < grants_q.size() && k < 4; k++)
            check_val("t3_order", grants_q[k], k % 2);
        wait_idle(50, "t3_idle");

        // 4. req1 reads back address 10
        req_write[1] = 1'b0; cmd_addr[1] = 32'd10; cmd_wdata[1] = 32'hdead;
        req_valid[1] = 1'b1;
        wait_done(50, "t4_done_seen");
        check_val("t4_done", done, 3'b010);
        check_val("t4_rdata", rdata, 20);
        for (int c = 0; c < 3; c++) step();
        check_val("t4_rdata_hold", rdata, 20);

        // 5. three wait states, exactly one completion
        cfg_wait = 3;
        req_write[0] = 1'b1; cmd_addr[0] = 32'd3; cmd_wdata[0] = 32'h33;
        req_valid[0] = 1'b1;
        base = n_done_seen;
        for (int c = 0; c < 30; c++) step();
        check_val("t5_one_done", n_done_seen - base, 1);
        check_val("t5_mem", slv_mem[3], 32'h33);
        cfg_wait = 0;

        // 6. reset during the ACCESS wait
        cfg_wait = 8;
        req_write[1] = 1'b1; cmd_addr[1] = 32'd5; cmd_wdata[1] = 32'h55;
        req_valid[1] = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            step();
            if (m_st == M_ACCESS) hit = 1'b1;
        end
        check_val("t6_reach_access", hit, 1);
        step();
        prst = 1'b0;
        req_write[0] = 1'b1; cmd_addr[0] = 32'd6; cmd_wdata[0] = 32'h66;
        req_valid[0] = 1'b1;
        step();
        check_val("t6_done", done, 0);
        check_val("t6_mem5", slv_mem[5], 0);
        prst = 1'b1;
        cfg_wait = 0;
        step();
        check_val("t6_grant0", grant, 3'b001);
        wait_idle(100, "t6_idle");
        check_val("t6_mem6", slv_mem[6], 32'h66);

        // randomized traffic against the model
        rand_mode = 1'b1;
        for (int c = 0; c < 3000; c++) step();
        drain = 1'b1;
        prst = 1'b1;
        wait_idle(1000, "drain_idle");
        for (int k = 0; k < 16; k++) check_val("final_mem", slv_mem[k], ref_mem[k]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
